// File: rtl/risc_fsm_controller.sv
// rtl/risc_fsm_controller.sv - Moore sequencer for the Simple RISC Machine datapath
// Outputs are registered alongside the state; illegal is decoded directly in DECODE.
module risc_fsm_controller #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s,
   input  logic [2:0]           opcode,
   input  logic [1:0]           op,
   output logic                 w,
   output logic [2:0]           nsel,
   output logic                 loada,
   output logic                 loadb,
   output logic                 asel,
   output logic                 bsel,
   output logic                 loadc,
   output logic                 loads,
   output logic [1:0]           vsel,
   output logic                 write,
   output logic                 illegal,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
   } state_t;

   typedef enum logic [1:0] {C_IMM, C_ALU2, C_CMP, C_ALU1} class_t;

   // {w, nsel, loada, loadb, asel, bsel, loadc, loads, vsel, write}
   typedef logic [12:0] outs_t;

   state_t                 state, nxt_state;
   class_t                 cls, nxt_cls, dec_cls;
   logic                   dec_legal;
   logic                   retire;
   outs_t                  outs_q;
   logic [CNT_WIDTH-1:0]   cnt_q;

   function automatic outs_t outs_of(input state_t st, input class_t c);
      outs_t o;
      o = '0;
      case (st)
         S_WAIT:      o[12]   = 1'b1;
         S_WRITE_IMM: begin o[11:9] = 3'b100; o[2:1] = 2'b01; o[0] = 1'b1; end
         S_GET_A:     begin o[11:9] = 3'b100; o[8] = 1'b1; end
         S_GET_B:     begin o[11:9] = 3'b001; o[7] = 1'b1; end
         S_ALU: begin
            o[6] = (c == C_ALU1);
            o[4] = 1'b1;
            o[3] = (c == C_CMP);
         end
         S_WRITE_REG: begin o[11:9] = 3'b010; o[0] = 1'b1; end
         default:     o = '0;
      endcase
      return o;
   endfunction

   always_comb begin
      dec_legal = 1'b1;
      dec_cls   = C_IMM;
      if (opcode == 3'b110 && op == 2'b10)      dec_cls = C_IMM;
      else if (opcode == 3'b110 && op == 2'b00) dec_cls = C_ALU1;
      else if (opcode == 3'b101) begin
         case (op)
            2'b01:   dec_cls = C_CMP;
            2'b11:   dec_cls = C_ALU1;
            default: dec_cls = C_ALU2;
         endcase
      end else begin
         dec_legal = 1'b0;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cls   = cls;
      retire    = 1'b0;
      case (state)
         S_WAIT: if (s) nxt_state = S_DECODE;
         S_DECODE: begin
            nxt_cls = dec_cls;
            if (!dec_legal)            nxt_state = S_WAIT;
            else if (dec_cls == C_IMM) nxt_state = S_WRITE_IMM;
            else if (dec_cls == C_ALU1) nxt_state = S_GET_B;
            else                       nxt_state = S_GET_A;
         end
         S_WRITE_IMM: begin nxt_state = S_WAIT; retire = 1'b1; end
         S_GET_A:     nxt_state = S_GET_B;
         S_GET_B:     nxt_state = S_ALU;
         S_ALU: begin
            if (cls == C_CMP) begin nxt_state = S_WAIT; retire = 1'b1; end
            else              nxt_state = S_WRITE_REG;
         end
         S_WRITE_REG: begin nxt_state = S_WAIT; retire = 1'b1; end
         default:     nxt_state = S_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_WAIT;
         cls    <= C_IMM;
         cnt_q  <= '0;
         outs_q <= outs_of(S_WAIT, C_IMM);
      end else begin
         state  <= nxt_state;
         cls    <= nxt_cls;
         outs_q <= outs_of(nxt_state, nxt_cls);
         if (retire) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign {w, nsel, loada, loadb, asel, bsel, loadc, loads, vsel, write} = outs_q;
   assign illegal     = (state == S_DECODE) && !dec_legal;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_risc_fsm_controller.sv
// tb/tb_risc_fsm_controller.sv - directed bench for risc_fsm_controller
module tb_risc_fsm_controller;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, s;
   logic [2:0]    opcode;
   logic [1:0]    op;
   logic          w, loada, loadb, asel, bsel, loadc, loads, write, illegal;
   logic [2:0]    nsel;
   logic [1:0]    vsel;
   logic [CW-1:0] instr_count;

   int errors = 0;
   int checks = 0;

   // {w, nsel, loada, loadb, asel, bsel, loadc, loads, vsel, write, illegal}
   localparam logic [13:0] E_WAIT  = 14'b1_000_0_0_0_0_0_0_00_0_0;
   localparam logic [13:0] E_DEC   = 14'b0_000_0_0_0_0_0_0_00_0_0;
   localparam logic [13:0] E_ILL   = 14'b0_000_0_0_0_0_0_0_00_0_1;
   localparam logic [13:0] E_WIMM  = 14'b0_100_0_0_0_0_0_0_01_1_0;
   localparam logic [13:0] E_GETA  = 14'b0_100_1_0_0_0_0_0_00_0_0;
   localparam logic [13:0] E_GETB  = 14'b0_001_0_1_0_0_0_0_00_0_0;
   localparam logic [13:0] E_ALU2  = 14'b0_000_0_0_0_0_1_0_00_0_0;
   localparam logic [13:0] E_ALUC  = 14'b0_000_0_0_0_0_1_1_00_0_0;
   localparam logic [13:0] E_ALU1  = 14'b0_000_0_0_1_0_1_0_00_0_0;
   localparam logic [13:0] E_WREG  = 14'b0_010_0_0_0_0_0_0_00_1_0;

   risc_fsm_controller #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
      .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .asel(asel),
      .bsel(bsel), .loadc(loadc), .loads(loads), .vsel(vsel),
      .write(write), .illegal(illegal), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] outs();
      return {w, nsel, loada, loadb, asel, bsel, loadc, loads, vsel, write, illegal};
   endfunction

   task automatic step(input string tag, input logic [13:0] exp);
      logic [13:0] got;
      @(posedge clk);
      #1;
      got = outs();
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s outputs got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [CW-1:0] exp);
      checks++;
      assert (instr_count === exp) else begin
         errors++;
         $error("FAIL %s instr_count got=%0d exp=%0d", tag, instr_count, exp);
      end
   endtask

   task automatic start(input string tag, input logic [2:0] opc, input logic [1:0] o,
                        input logic [13:0] exp_dec);
      s = 1'b1; opcode = opc; op = o;
      step({tag, "_decode"}, exp_dec);
      s = 1'b0;
   endtask

   initial begin
      reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
      step("reset", E_WAIT);
      step("reset2", E_WAIT);
      chk_cnt("reset", 4'd0);
      reset = 1'b0;
      step("idle", E_WAIT);

      start("movi", 3'b110, 2'b10, E_DEC);
      step("movi_wimm", E_WIMM);
      step("movi_wait", E_WAIT);
      chk_cnt("movi", 4'd1);

      start("add", 3'b101, 2'b00, E_DEC);
      step("add_geta", E_GETA);
      step("add_getb", E_GETB);
      step("add_alu", E_ALU2);
      step("add_wreg", E_WREG);
      step("add_wait", E_WAIT);
      chk_cnt("add", 4'd2);

      start("cmp", 3'b101, 2'b01, E_DEC);
      step("cmp_geta", E_GETA);
      step("cmp_getb", E_GETB);
      step("cmp_alu", E_ALUC);
      step("cmp_wait", E_WAIT);
      chk_cnt("cmp", 4'd3);

      start("mvn", 3'b101, 2'b11, E_DEC);
      step("mvn_getb", E_GETB);
      step("mvn_alu", E_ALU1);
      step("mvn_wreg", E_WREG);
      step("mvn_wait", E_WAIT);
      chk_cnt("mvn", 4'd4);

      start("movr", 3'b110, 2'b00, E_DEC);
      step("movr_getb", E_GETB);
      step("movr_alu", E_ALU1);
      step("movr_wreg", E_WREG);
      step("movr_wait", E_WAIT);
      chk_cnt("movr", 4'd5);

      start("and", 3'b101, 2'b10, E_DEC);
      step("and_geta", E_GETA);
      step("and_getb", E_GETB);
      step("and_alu", E_ALU2);
      step("and_wreg", E_WREG);
      step("and_wait", E_WAIT);
      chk_cnt("and", 4'd6);

      start("ill111", 3'b111, 2'b00, E_ILL);
      step("ill111_wait", E_WAIT);
      chk_cnt("ill111", 4'd6);
      start("ill110_01", 3'b110, 2'b01, E_ILL);
      step("ill110_wait", E_WAIT);
      chk_cnt("ill110", 4'd6);

      // s held high: second instruction starts right after the single WAIT cycle
      s = 1'b1; opcode = 3'b110; op = 2'b10;
      step("b2b_dec1", E_DEC);
      step("b2b_wimm1", E_WIMM);
      step("b2b_wait", E_WAIT);
      step("b2b_dec2", E_DEC);
      s = 1'b0;
      step("b2b_wimm2", E_WIMM);
      step("b2b_wait2", E_WAIT);
      chk_cnt("b2b", 4'd8);

      start("rst_add", 3'b101, 2'b00, E_DEC);
      step("rst_geta", E_GETA);
      step("rst_getb", E_GETB);
      reset = 1'b1;
      step("rst_mid", E_WAIT);
      chk_cnt("rst_mid", 4'd0);
      reset = 1'b0;
      step("rst_idle", E_WAIT);
      chk_cnt("rst_idle", 4'd0);

      for (int i = 1; i <= 16; i++) begin
         start("wrap", 3'b110, 2'b10, E_DEC);
         step("wrap_wimm", E_WIMM);
         step("wrap_wait", E_WAIT);
         chk_cnt("wrap", 4'(i % 16));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/risc_fsm_controller.md
Name: risc_fsm_controller

Overview:
- Moore state machine that sequences the Simple RISC Machine datapath (register file, A/B/C registers, ALU, status register) for one instruction at a time.
- Consumes the decoded opcode/op fields and a start strobe.
- Drives nsel to the instruction decoder plus all datapath load/select/write strobes.
- Asserts w while idle; keeps a retired-instruction counter and flags unsupported encodings.

Parameters:
CNT_WIDTH, 16, width of retired-instruction counter instr_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
s  input  1  start; sampled only in WAIT
opcode  input  3  instruction[15:13] from decoder
op  input  2  instruction[12:11] from decoder
w  output  1  1 = idle in WAIT, ready for s
nsel  output  3  one-hot register select: 001 Rm, 010 Rd, 100 Rn, 000 none
loada  output  1  load A register
loadb  output  1  load B register
asel  output  1  1 = ALU A input forced to 0
bsel  output  1  1 = ALU B input from sximm5 (always 0 in this block)
loadc  output  1  load C register
loads  output  1  load status register
vsel  output  2  writeback mux: 00 C, 01 sximm8, 10 PC (unused), 11 mdata (unused)
write  output  1  register-file write enable
illegal  output  1  one-cycle pulse on unsupported opcode/op
instr_count  output  CNT_WIDTH  count of completed instructions

Behaviour:
- Supported instructions:
  - MOV Rn,#imm8: opcode 110, op 10
  - MOV Rd,Rm: opcode 110, op 00
  - ADD: opcode 101, op 00
  - CMP: opcode 101, op 01
  - AND: opcode 101, op 10
  - MVN: opcode 101, op 11
- All others are illegal.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
- Outputs are pure functions of state and latched class. Any strobe not listed for a state is 0, nsel is 000 and vsel is 00.
- Per-state outputs:
  - WAIT: w=1. If s, go to DECODE; otherwise stay.
  - DECODE: no strobes. Latches the instruction class (IMM, ALU2 = ADD/AND, CMP, ALU1 = MOV-reg/MVN).
    - IMM goes to WRITE_IMM.
    - ALU2 and CMP go to GET_A.
    - ALU1 goes to GET_B.
    - Illegal: illegal=1 (combinational in DECODE), return to WAIT, count unchanged.
  - WRITE_IMM: nsel=100, vsel=01, write=1. Go to WAIT, count +1.
  - GET_A: nsel=100, loada=1. Go to GET_B.
  - GET_B: nsel=001, loadb=1. Go to ALU.
  - ALU: bsel=0, loadc=1.
    - asel=1 for ALU1, else 0.
    - loads=1 only for CMP.
    - CMP goes to WAIT with count +1; all other classes go to WRITE_REG.
  - WRITE_REG: nsel=010, vsel=00, write=1. Go to WAIT, count +1.
- Latency, counted as cycles with w=0 after s is sampled:
  - MOV imm: 2
  - MOV reg / MVN: 4
  - CMP: 4
  - ADD / AND: 5
- opcode and op must stay stable from DECODE until return to WAIT; the block samples them only in DECODE.
- s is ignored outside WAIT. If s is held high, a new instruction starts in the cycle after w returns to 1; there is no extra idle cycle beyond the single WAIT cycle.
- instr_count increments on the edge leaving the final state of a legal instruction and wraps modulo 2^CNT_WIDTH. It does not saturate.
- Reset: on any edge with reset=1, state goes to WAIT and instr_count goes to 0, regardless of current state or s.
  - After reset: w=1 and all strobes, illegal, nsel and vsel are 0.
  - Reset mid-instruction abandons it with no further write; it is not counted.
- write is never asserted with nsel=000.

Test Plan:
- Reset, then s=1 with opcode=110, op=10 → DECODE, WRITE_IMM (nsel=100, vsel=01, write=1), WAIT; w low for exactly 2 cycles; instr_count=1.
- opcode=101, op=00 (ADD) → GET_A (nsel=100, loada), GET_B (nsel=001, loadb), ALU (asel=0, loadc=1, loads=0), WRITE_REG (nsel=010, write); w low 5 cycles; count +1.
- opcode=101, op=01 (CMP) → ALU cycle has loads=1, loadc=1; write is never asserted; w low 4 cycles; count +1.
- opcode=101, op=11 (MVN) and opcode=110, op=00 (MOV reg) → GET_A skipped; ALU has asel=1; write in WRITE_REG; w low 4 cycles.
- opcode=111 → illegal=1 for one cycle in DECODE, back to WAIT after 1 cycle, no write, count unchanged.
- reset asserted during GET_B of ADD → next cycle w=1, all strobes 0, count=0.
- Run 2^CNT_WIDTH MOV imm instructions with CNT_WIDTH=4 → count wraps from 15 to 0.
